receptor_medida_trena: RTL and testbench
========================================

Name: receptor_medida_trena

Overview:
- Receive side of the digital tape-measure serial link.
- Consumes bytes from the UART receiver and parses the 4-character ASCII frame: hundreds digit, tens digit, units digit, terminator (default '#').
- On a well-formed frame, latches the BCD digits and their binary value and pulses medida_valida.
- Malformed or stalled frames pulse erro and resynchronise.
- Sits between the UART RX and the display or host logic on the receiving board.

Parameters:
- CARACTER_FINAL, 8'h23, terminator byte expected after the units digit ('#').
- TIMEOUT_CICLOS, 50000000, maximum idle clock cycles allowed between bytes within a frame (1 s at 50 MHz). Counter width is ceil(log2(TIMEOUT_CICLOS)).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- dado  input  8  received byte; valid only when dado_valido=1.
- dado_valido  input  1  one-cycle strobe from UART RX, one per byte.
- centena  output  4  BCD hundreds of the last valid frame.
- dezena  output  4  BCD tens of the last valid frame.
- unidade  output  4  BCD units of the last valid frame.
- medida_bin  output  10  centena*100 + dezena*10 + unidade of the last valid frame.
- medida_valida  output  1  one-cycle pulse: a new frame was accepted.
- erro  output  1  one-cycle pulse: frame rejected.
- db_estado  output  4  current state code, for debug.

Behaviour:
- Reset is asynchronous and active-high. Clock is clock.
- Reset values:
  - state = aguarda_centena.
  - centena, dezena, unidade, medida_bin = 0.
  - medida_valida, erro = 0.
  - shadow digit registers = 0; timeout counter = 0.
- Digit byte: 8'h30..8'h39. The digit value is dado[3:0]. Any other byte in a digit position is an error.
- State codes (db_estado):
  - aguarda_centena 0
  - aguarda_dezena 1
  - aguarda_unidade 2
  - aguarda_final 3
  - valida 4
  - erro 4'hE
  - any illegal code returns to aguarda_centena.
- Transitions, each evaluated when dado_valido=1:
  - aguarda_centena: digit -> store shadow hundreds, go to aguarda_dezena. Non-digit -> erro.
  - aguarda_dezena: digit -> store shadow tens, go to aguarda_unidade. Non-digit -> erro.
  - aguarda_unidade: digit -> store shadow units, go to aguarda_final. Non-digit -> erro.
  - aguarda_final: dado == CARACTER_FINAL -> valida. Any other byte -> erro.
  - valida: unconditionally -> aguarda_centena after 1 cycle.
  - erro: unconditionally -> aguarda_centena after 1 cycle.
- dado_valido=0 in any aguarda_* state holds the state, subject to timeout.
- Output update: on the edge that moves aguarda_final -> valida, register centena/dezena/unidade from the shadow registers and medida_bin from their weighted sum. medida_bin is a 10-bit unsigned value, maximum 999, so it never overflows.
- Outputs are held at all other times. An error never alters centena, dezena, unidade or medida_bin.
- medida_valida = 1 only in state valida. erro = 1 only in state erro. Both are Moore outputs.
- Latency: medida_valida and the new outputs become visible in the cycle after dado_valido carries the terminator.
- Timeout:
  - The counter is cleared on every accepted byte and whenever the state is aguarda_centena, valida or erro.
  - It increments each cycle in aguarda_dezena, aguarda_unidade and aguarda_final while dado_valido=0.
  - When the counter reaches TIMEOUT_CICLOS-1, the next state is erro.
  - aguarda_centena never times out.
- Simultaneous events: dado_valido in the same cycle the timeout is reached wins; the byte is processed normally and the counter is cleared.
- dado_valido during valida or erro is ignored. The UART byte spacing makes this unreachable in the system.
- Resynchronisation: after erro, the next byte is treated as a new hundreds digit. A stray terminator therefore produces one more erro and then realigns.
- Reset mid-frame: partial digits are discarded, state returns to aguarda_centena, and outputs are cleared to 0.

Test Plan:
- Bytes '1','2','3','#' (0x31,0x32,0x33,0x23) -> centena=1, dezena=2, unidade=3, medida_bin=123; medida_valida=1 for exactly 1 cycle after the '#' strobe; erro stays 0.
- After the 123 frame, bytes '4','5','6','X' -> erro pulses 1 cycle after 'X'; outputs still 1/2/3/123; db_estado shows 3 -> E -> 0.
- Bytes '9','A' -> erro after 'A'; then '0','0','7','#' -> medida_bin=7 and medida_valida pulses (resync works).
- With TIMEOUT_CICLOS=100: bytes '5','5', then idle -> erro pulses once 100 cycles after the second strobe; aguarda_centena idle for 1000 cycles -> no erro.
- Bytes '9','9','9','#' -> medida_bin=999 (10'h3E7), BCD 9/9/9.
- Bytes '1','2', then assert reset for 2 cycles, then '3','4','5','#' -> outputs 0 after reset, then medida_bin=345.

Source files
------------

// File: rtl/receptor_medida_trena.sv
// rtl/receptor_medida_trena.sv - tape-measure frame receiver: parses "DDD<term>" from UART RX bytes
// Latches BCD digits and binary value on a good frame; pulses erro on malformed or stalled frames.
module receptor_medida_trena #(
    parameter logic [7:0] CARACTER_FINAL = 8'h23,
    parameter int         TIMEOUT_CICLOS = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] dado,
    input  logic       dado_valido,
    output logic [3:0] centena,
    output logic [3:0] dezena,
    output logic [3:0] unidade,
    output logic [9:0] medida_bin,
    output logic       medida_valida,
    output logic       erro,
    output logic [3:0] db_estado
);
    localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        AGUARDA_CENTENA = 4'h0,
        AGUARDA_DEZENA  = 4'h1,
        AGUARDA_UNIDADE = 4'h2,
        AGUARDA_FINAL   = 4'h3,
        VALIDA          = 4'h4,
        ERRO            = 4'hE
    } estado_t;

    estado_t       estado;
    logic [3:0]    sombra_centena;
    logic [3:0]    sombra_dezena;
    logic [3:0]    sombra_unidade;
    logic [CW-1:0] contador;
    logic          eh_digito;
    logic          estourou;
    logic [9:0]    soma;

    assign eh_digito = (dado[7:4] == 4'h3) && (dado[3:0] <= 4'd9);
    assign estourou  = (contador == LIMITE);
    assign db_estado = estado;
    assign soma      = {6'd0, sombra_centena} * 10'd100
                     + {6'd0, sombra_dezena}  * 10'd10
                     + {6'd0, sombra_unidade};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado         <= AGUARDA_CENTENA;
            sombra_centena <= 4'd0;
            sombra_dezena  <= 4'd0;
            sombra_unidade <= 4'd0;
            contador       <= '0;
            centena        <= 4'd0;
            dezena         <= 4'd0;
            unidade        <= 4'd0;
            medida_bin     <= 10'd0;
            medida_valida  <= 1'b0;
            erro           <= 1'b0;
        end else begin
            medida_valida <= 1'b0;
            erro          <= 1'b0;
            case (estado)
                AGUARDA_CENTENA: begin
                    contador <= '0;
                    if (dado_valido) begin
                        if (eh_digito) begin
                            sombra_centena <= dado[3:0];
                            estado         <= AGUARDA_DEZENA;
                        end else begin
                            estado <= ERRO;
                            erro   <= 1'b1;
                        end
                    end
                end
                AGUARDA_DEZENA, AGUARDA_UNIDADE, AGUARDA_FINAL: begin
                    if (!dado_valido) begin
                        // A byte arriving on the timeout cycle takes the other branch and wins.
                        if (estourou) begin
                            contador <= '0;
                            estado   <= ERRO;
                            erro     <= 1'b1;
                        end else begin
                            contador <= contador + 1'b1;
                        end
                    end else begin
                        contador <= '0;
                        if (estado == AGUARDA_FINAL) begin
                            if (dado == CARACTER_FINAL) begin
                                centena       <= sombra_centena;
                                dezena        <= sombra_dezena;
                                unidade       <= sombra_unidade;
                                medida_bin    <= soma;
                                medida_valida <= 1'b1;
                                estado        <= VALIDA;
                            end else begin
                                estado <= ERRO;
                                erro   <= 1'b1;
                            end
                        end else if (!eh_digito) begin
                            estado <= ERRO;
                            erro   <= 1'b1;
                        end else if (estado == AGUARDA_DEZENA) begin
                            sombra_dezena <= dado[3:0];
                            estado        <= AGUARDA_UNIDADE;
                        end else begin
                            sombra_unidade <= dado[3:0];
                            estado         <= AGUARDA_FINAL;
                        end
                    end
                end
                VALIDA, ERRO: begin
                    contador <= '0;
                    estado   <= AGUARDA_CENTENA;
                end
                default: begin
                    contador <= '0;
                    estado   <= AGUARDA_CENTENA;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_receptor_medida_trena.sv
// tb/tb_receptor_medida_trena.sv - randomized self-checking bench for receptor_medida_trena
// A frame-buffer reference model predicts every output after each clock edge.
module tb_receptor_medida_trena;
    localparam int T = 100;
    localparam logic [7:0] FIM = 8'h23;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] dado = 8'h00;
    logic       dado_valido = 1'b0;
    logic [3:0] centena, dezena, unidade, db_estado;
    logic [9:0] medida_bin;
    logic       medida_valida, erro;

    receptor_medida_trena #(.CARACTER_FINAL(FIM), .TIMEOUT_CICLOS(T)) dut (
        .clock(clock), .reset(reset), .dado(dado), .dado_valido(dado_valido),
        .centena(centena), .dezena(dezena), .unidade(unidade),
        .medida_bin(medida_bin), .medida_valida(medida_valida),
        .erro(erro), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: digits received so far in the current frame, idle time, pending pulse.
    int   q[$];
    int   idle = 0;
    bit   pv = 0, pe = 0;
    int   e_c = 0, e_d = 0, e_u = 0;

    function automatic bit is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    always @(posedge clock) begin
        bit ev, ee;
        int est;
        ev = 0;
        ee = 0;
        if (reset) begin
            q.delete();
            idle = 0;
            e_c = 0; e_d = 0; e_u = 0;
        end else if (pv || pe) begin
            idle = 0;
        end else if (dado_valido) begin
            idle = 0;
            if (q.size() < 3) begin
                if (is_digit(dado)) q.push_back(int'(dado) - 48);
                else begin ee = 1; q.delete(); end
            end else begin
                if (dado == FIM) begin
                    ev = 1; e_c = q[0]; e_d = q[1]; e_u = q[2];
                end else ee = 1;
                q.delete();
            end
        end else if (q.size() > 0) begin
            if (idle >= T - 1) begin ee = 1; q.delete(); idle = 0; end
            else idle++;
        end
        pv = ev;
        pe = ee;
        est = pv ? 4 : (pe ? 14 : q.size());
        #1;
        check("bcd", {4'd0, centena, dezena, unidade}, 16'(e_c * 256 + e_d * 16 + e_u));
        check("medida_bin", {6'd0, medida_bin}, 16'(e_c * 100 + e_d * 10 + e_u));
        check("medida_valida", {15'd0, medida_valida}, {15'd0, pv});
        check("erro", {15'd0, erro}, {15'd0, pe});
        check("db_estado", {12'd0, db_estado}, 16'(est));
    end

    task automatic espera(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic envia(input logic [7:0] b, input int gap);
        @(negedge clock);
        dado = b;
        dado_valido = 1'b1;
        @(negedge clock);
        dado_valido = 1'b0;
        dado = 8'($urandom);
        espera(gap);
    endtask

    task automatic envia_str(input string s);
        for (int i = 0; i < s.len(); i++) envia(s[i], 2);
    endtask

    initial begin
        espera(3);
        reset = 1'b0;
        envia_str("123#");
        envia_str("456X");
        envia_str("9A");
        envia_str("007#");
        envia_str("55");
        espera(T + 10);
        espera(1000);
        envia_str("999#");
        envia_str("12");
        @(negedge clock); reset = 1'b1;
        espera(2);
        reset = 1'b0;
        envia_str("345#");
        envia_str("#");
        envia_str("321#");
        for (int f = 0; f < 300; f++) begin
            int kind, n;
            kind = $urandom_range(0, 9);
            n = (kind == 9) ? $urandom_range(1, 3) : 3;
            for (int k = 0; k < n; k++) begin
                logic [7:0] b;
                b = 8'(8'h30 + $urandom_range(0, 9));
                if (kind == 6 && k == 1) b = 8'($urandom_range(8'h3A, 8'h7E));
                envia(b, (kind == 9 && k == n - 1) ? $urandom_range(T - 3, T + 5)
                                                   : $urandom_range(1, 4));
            end
            if (kind == 7) envia(8'h2A, $urandom_range(1, 4));
            else if (kind == 8) begin envia(FIM, 2); envia(FIM, 2); end
            else if (kind != 9) envia(FIM, $urandom_range(1, 4));
        end
        espera(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
